// File: rtl/i2s_tx.sv
// i2s_tx: mono I2S transmitter. A one-deep holding register is loaded by
// the sample_valid strobe and copied into the frame register at each
// frame boundary. The frame register is shifted out MSB-first into both
// the left and the right slot, with the standard I2S one-bit delay.
// bclk is derived from clk through a divider. Dropping enable lets the
// current frame finish before the serial clocks stop.
// Optional build macro: I2S_TX_UNDERRUN_EN adds a saturating
// underrun_count output.
module i2s_tx #(
  parameter int data_width = 16,
  parameter int bclk_div   = 4,
  parameter int slot_width = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [data_width-1:0] sample_in,
  input  logic                  sample_valid,
  output logic                  bclk,
  output logic                  lrclk,
  output logic                  sdata,
  output logic                  frame_start,
  output logic                  running
`ifdef I2S_TX_UNDERRUN_EN
  ,
  output logic [15:0]           underrun_count
`endif
);

  localparam int DIV_W = (bclk_div > 1) ? $clog2(bclk_div) : 1;
  localparam int BIT_W = $clog2(2 * slot_width);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(bclk_div - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(2 * slot_width - 1);
  localparam logic [BIT_W-1:0] SLOT_W   = BIT_W'(slot_width);
  localparam logic [BIT_W-1:0] DATA_W   = BIT_W'(data_width);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t state;
  state_t next_state;

  logic [DIV_W-1:0]      div_cnt;
  logic [BIT_W-1:0]      bit_cnt;
  logic [data_width-1:0] holding;
  logic [data_width-1:0] frame_reg;
  logic                  fresh;

  logic                  div_tick;
  logic                  bclk_fall;
  logic                  frame_end;
  logic                  boundary;
  logic [BIT_W-1:0]      next_bit;
  logic [BIT_W-1:0]      slot_pos;
  logic [data_width-1:0] frame_shifted;
  logic                  next_sdata;

  // Divider wrap, bclk falling edge, frame end and frame boundary detection.
  always_comb begin
    div_tick  = (state != IDLE) && (div_cnt == DIV_LAST);
    bclk_fall = div_tick && bclk;
    frame_end = bclk_fall && (bit_cnt == BIT_LAST);
    boundary  = ((state == IDLE) && enable) ||
                ((state == RUN) && frame_end) ||
                ((state == DRAIN) && frame_end && enable);
  end

  // Bit position, lrclk and sdata values that take effect on the next bclk fall.
  always_comb begin
    // NOTE: every signal gets a default first, so no path leaves one unassigned and no latch is inferred.
    next_bit      = (bit_cnt == BIT_LAST) ? '0 : bit_cnt + BIT_W'(1);
    slot_pos      = (next_bit >= SLOT_W) ? next_bit - SLOT_W : next_bit;
    frame_shifted = frame_reg << (slot_pos - BIT_W'(1));
    next_sdata    = 1'b0;
    if ((slot_pos >= BIT_W'(1)) && (slot_pos <= DATA_W)) begin
      next_sdata = frame_shifted[data_width-1];
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments, so every register samples its pre-edge inputs.
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic: run on enable, and drain to the end of the frame when enable drops.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (enable) next_state = RUN;
      RUN:     if (!enable) next_state = DRAIN;
      DRAIN: begin
        if (enable) begin
          next_state = RUN;
        end else if (frame_end) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    running = (state != IDLE);
  end

  // Holding register, fresh flag and frame register hand-off.
  always_ff @(posedge clk) begin
    // NOTE: the sample registers are cleared on reset, so a restart never replays stale audio.
    if (reset) begin
      holding     <= '0;
      fresh       <= 1'b0;
      frame_reg   <= '0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= boundary;
      if (boundary) begin
        frame_reg <= holding;
      end
      // A strobe on the boundary edge stays fresh for the following frame.
      if (sample_valid) begin
        holding <= sample_in;
        fresh   <= 1'b1;
      end else if (boundary) begin
        fresh <= 1'b0;
      end
    end
  end

  // bclk divider, bit counter and serial outputs.
  always_ff @(posedge clk) begin
    if (reset || (state == IDLE) || (next_state == IDLE)) begin
      // Idle, leaving drain, or reset: every serial line is parked low and the counters are cleared.
      div_cnt <= '0;
      bit_cnt <= '0;
      bclk    <= 1'b0;
      lrclk   <= 1'b0;
      sdata   <= 1'b0;
    end else begin
      div_cnt <= div_tick ? '0 : div_cnt + DIV_W'(1);
      if (div_tick) begin
        bclk <= ~bclk;
      end
      if (bclk_fall) begin
        bit_cnt <= next_bit;
        lrclk   <= (next_bit >= SLOT_W);
        sdata   <= next_sdata;
      end
    end
  end

`ifdef I2S_TX_UNDERRUN_EN
  // Count boundaries that had no new sample. The entry boundary from IDLE is excluded.
  always_ff @(posedge clk) begin
    if (reset) begin
      underrun_count <= '0;
    end else if (boundary && (state != IDLE) && !fresh &&
                 (underrun_count != 16'hFFFF)) begin
      underrun_count <= underrun_count + 16'd1;
    end
  end
`endif

endmodule

// File: doc/i2s_tx.md
I2S_TX -- requirements
Module: i2s_tx

Interface
REQ-001 Parameter data_width, default 16: sample width in bits, signed two's complement.
REQ-002 Parameter bclk_div, default 4: clk cycles per bclk half-period; legal values are 1 or more.
REQ-003 Parameter slot_width, default 32: bclk periods per channel slot; legal range is data_width+1 to 255.
REQ-004 Port clk, input, 1: the single clock; all logic is on its rising edge.
REQ-005 Port reset, input, 1: synchronous, active-high reset.
REQ-006 Port enable, input, 1: run request; level-sensitive.
REQ-007 Port sample_in, input, data_width: mixed output sample, driven by mixer out_sample.
REQ-008 Port sample_valid, input, 1: one-cycle strobe qualifying sample_in, driven by mixer out_sample_ready.
REQ-009 Port bclk, output, 1: serial bit clock.
REQ-010 Port lrclk, output, 1: word select; 0 = left slot, 1 = right slot.
REQ-011 Port sdata, output, 1: serial data.
REQ-012 Port frame_start, output, 1: one-cycle pulse when a frame begins and the holding register is consumed.
REQ-013 Port running, output, 1: high while the serial clocks are active.

Function
REQ-014 sample_valid high latches sample_in into the holding register on the same edge and sets the fresh flag; no backpressure exists, and a later strobe overwrites an unconsumed sample.
REQ-015 FSM states: IDLE, RUN and DRAIN.
- IDLE: bclk, lrclk and sdata are held at 0; running=0.
- IDLE -> RUN when enable=1.
- RUN -> DRAIN when enable=0.
- DRAIN -> RUN if enable returns to 1 before the frame ends.
- DRAIN -> IDLE on the last bclk falling edge of the frame.
REQ-016 In RUN/DRAIN, the divider counts 0..bclk_div-1; bclk toggles on the cycle the divider wraps.
REQ-017 The bit counter (0..2*slot_width-1) advances on each bclk falling edge and wraps to 0 at the end of a frame.
REQ-018 lrclk=1 while the bit counter is at or above slot_width; lrclk and sdata change only on bclk falling edges.
REQ-019 On entry to RUN from IDLE, the first frame starts immediately.
- bit counter = 0; bclk low.
- The first bclk rising edge occurs bclk_div cycles later.
REQ-020 Frame boundary (entry to RUN, or bit counter wrap while in RUN): the holding register is copied to the frame register, fresh is cleared, and frame_start pulses for 1 cycle.
REQ-021 If fresh=0 at a frame boundary, the previous frame register value is retransmitted (hold-last, no zero insertion).
REQ-022 Bit layout within each slot, for slot-relative bit position p:
- p=0: sdata=0 (I2S one-bit delay).
- p=1..data_width: frame register bits MSB-first, bit data_width-1 first.
- p above data_width: sdata=0.
REQ-023 Both slots carry the same frame register value (mono duplicated to left and right).
REQ-024 If sample_valid coincides with a frame boundary, the boundary consumes the old holding value and the new sample stays fresh for the next frame.
REQ-025 running=1 in RUN and DRAIN.

Reset
REQ-026 Reset overrides all activity, including mid-frame; on the next edge the following values apply:
- state=IDLE.
- bclk=0, lrclk=0, sdata=0, frame_start=0, running=0.
- divider, bit counter, holding register, frame register and fresh all cleared to 0.
REQ-027 Reset asserted together with sample_valid discards the sample.

Configuration
REQ-028 Macro I2S_TX_UNDERRUN_EN.
- When defined, adds output underrun_count [15:0], which increments at every frame boundary taken with fresh=0.
- The count saturates at 16'hFFFF and clears on reset.
- The first boundary after entering RUN from IDLE is not counted.
- When undefined, the port and counter are absent and behaviour is otherwise identical.

Verification
All scenarios use data_width=16, bclk_div=2, slot_width=32.
REQ-029 Startup: release reset with enable=1 and strobe sample 16'hA5C3 -> frame_start pulses, lrclk=0, sdata over slot bits 1..16 = 1010010111000011, bits 0 and 17..31 = 0, and the right slot carries the same bits.
REQ-030 Bit timing: steady RUN -> bclk period = 4 clk cycles, frame = 256 clk cycles, and lrclk changes only on the cycle bclk falls.
REQ-031 Underrun: no strobe for 3 frames after sample 16'h8001 -> each frame retransmits 16'h8001; with I2S_TX_UNDERRUN_EN defined, underrun_count=3.
REQ-032 Collision: strobe 16'h1234 on the frame_start cycle while holding=16'h7FFF -> current frame sends 16'h7FFF and the next frame sends 16'h1234.
REQ-033 Drain: drop enable at bit counter 10 -> frame completes, state=IDLE after bit 63, bclk, lrclk and sdata at 0, and running falls.
REQ-034 Mid-frame reset: assert reset at bit counter 40 for 1 cycle with enable=1 -> all outputs are 0 on the next edge, then a fresh frame starts with bit counter 0.
